// File: rtl/sprite_scaler_blit.sv
// Streams one positioned, integer-scaled sprite into the VGA raster through a sync ROM.
// Optional horizontal mirroring is compiled in with `define SPR_MIRROR_EN.
module sprite_scaler_blit #(
  parameter int SPR_W      = 84,
  parameter int SPR_H      = 67,
  parameter int SCALE      = 2,
  parameter int ADDR_W     = 13,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              enable,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic              flip_x,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_hit,
  output logic              blank_o
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SPR_H - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);

  typedef enum logic [0:0] {IDLE_FRAME = 1'b0, TRACK = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [9:0]          spr_x_r, spr_y_r, spr_x_s, spr_y_s;
  logic                flip_s;
  logic                frame_start_s, line_start_s, live_s;
  logic [ROW_W-1:0]    row_r, row_s;
  logic [COL_W-1:0]    col_r, col_s, col_addr_s;
  logic [SUB_W-1:0]    sub_y_r, sub_y_s, sub_x_r, sub_x_s;
  logic                row_act_r, row_act_s, col_act_r, col_act_s, in_spr_s;
  logic [ADDR_W-1:0]   row_base_r, row_base_s, addr_s, rom_addr_r;
  logic                in_s1_r, blank_s1_r, in_s2_r, blank_s2_r, hit_s;
  logic [IDX_W-1:0]    pix_idx_r;
  logic                pix_hit_r, blank_o_r;

  assign frame_start_s = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign line_start_s  = (DrawX == 10'd0);
  // At frame start the new position must already govern this very pixel.
  assign spr_x_s       = frame_start_s ? spr_x : spr_x_r;
  assign spr_y_s       = frame_start_s ? spr_y : spr_y_r;
  assign live_s        = frame_start_s || (state_r == TRACK);

`ifdef SPR_MIRROR_EN
  logic flip_x_r;

  // Mirror request shadow, refreshed only at frame start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      flip_x_r <= 1'b0;
    end else if (frame_start_s) begin
      flip_x_r <= flip_x;
    end else begin
      flip_x_r <= flip_x_r;
    end
  end

  assign flip_s = frame_start_s ? flip_x : flip_x_r;
`else
  logic flip_unused_s;
  assign flip_unused_s = flip_x;
  assign flip_s        = 1'b0;
`endif

  // Frame state machine: waits for the first frame start after reset.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE_FRAME: begin
        if (frame_start_s) state_s = TRACK;
        else               state_s = IDLE_FRAME;
      end
      TRACK:   state_s = TRACK;
      default: state_s = IDLE_FRAME;
    endcase
  end

  // Row stepping at each line start; a frame start drops any overhanging sprite.
  always_comb begin
    row_s      = row_r;
    sub_y_s    = sub_y_r;
    row_base_s = row_base_r;
    row_act_s  = frame_start_s ? 1'b0 : row_act_r;
    if (line_start_s && live_s && (DrawY == spr_y_s)) begin
      row_s      = ROW_W'(1'b0);
      sub_y_s    = SUB_W'(1'b0);
      row_base_s = ADDR_W'(1'b0);
      row_act_s  = 1'b1;
    end else if (line_start_s && row_act_s) begin
      if (sub_y_r == SUB_LAST) begin
        sub_y_s = SUB_W'(1'b0);
        if (row_r == ROW_LAST) begin
          row_act_s = 1'b0;
        end else begin
          row_s      = row_r + ROW_W'(1'b1);
          row_base_s = row_base_r + ROW_STEP;
        end
      end else begin
        sub_y_s = sub_y_r + SUB_W'(1'b1);
      end
    end else begin
      row_s   = row_r;
      sub_y_s = sub_y_r;
    end
  end

  // Column stepping, gated by the already-updated row state; never carries across lines.
  always_comb begin
    col_s     = col_r;
    sub_x_s   = sub_x_r;
    col_act_s = line_start_s ? 1'b0 : col_act_r;
    if (row_act_s && (DrawX == spr_x_s)) begin
      col_s     = COL_W'(1'b0);
      sub_x_s   = SUB_W'(1'b0);
      col_act_s = 1'b1;
    end else if (col_act_s) begin
      if (sub_x_r == SUB_LAST) begin
        sub_x_s = SUB_W'(1'b0);
        if (col_r == COL_LAST) col_act_s = 1'b0;
        else                   col_s     = col_r + COL_W'(1'b1);
      end else begin
        sub_x_s = sub_x_r + SUB_W'(1'b1);
      end
    end else begin
      col_s   = col_r;
      sub_x_s = sub_x_r;
    end
  end

  assign in_spr_s   = row_act_s && col_act_s;
  assign col_addr_s = flip_s ? (COL_LAST - col_s) : col_s;
  assign addr_s     = row_base_s + ADDR_W'(col_addr_s);
  assign hit_s      = in_s2_r && blank_s2_r && (rom_q != IDX_W'(TRANSP_IDX));

  // Frame state, position shadows and per-axis counters.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE_FRAME;
      spr_x_r    <= 10'd0;
      spr_y_r    <= 10'd0;
      row_r      <= ROW_W'(1'b0);
      col_r      <= COL_W'(1'b0);
      sub_y_r    <= SUB_W'(1'b0);
      sub_x_r    <= SUB_W'(1'b0);
      row_act_r  <= 1'b0;
      col_act_r  <= 1'b0;
      row_base_r <= ADDR_W'(1'b0);
    end else begin
      state_r    <= state_s;
      spr_x_r    <= spr_x_s;
      spr_y_r    <= spr_y_s;
      row_r      <= row_s;
      col_r      <= col_s;
      sub_y_r    <= sub_y_s;
      sub_x_r    <= sub_x_s;
      row_act_r  <= row_act_s;
      col_act_r  <= col_act_s;
      row_base_r <= row_base_s;
    end
  end

  // Address stage, ROM wait stage and output stage.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_r <= ADDR_W'(1'b0);
      in_s1_r    <= 1'b0;
      blank_s1_r <= 1'b0;
      in_s2_r    <= 1'b0;
      blank_s2_r <= 1'b0;
      pix_idx_r  <= IDX_W'(1'b0);
      pix_hit_r  <= 1'b0;
      blank_o_r  <= 1'b0;
    end else begin
      if (in_spr_s) rom_addr_r <= addr_s;
      else          rom_addr_r <= rom_addr_r;
      in_s1_r    <= in_spr_s && enable;
      blank_s1_r <= blank;
      in_s2_r    <= in_s1_r;
      blank_s2_r <= blank_s1_r;
      pix_hit_r  <= hit_s;
      pix_idx_r  <= hit_s ? rom_q : IDX_W'(1'b0);
      blank_o_r  <= blank_s2_r;
    end
  end

  assign rom_addr = rom_addr_r;
  assign pix_idx  = pix_idx_r;
  assign pix_hit  = pix_hit_r;
  assign blank_o  = blank_o_r;

endmodule

// File: tb/tb_sprite_scaler_blit.sv
// Bench for sprite_scaler_blit: directed pixel table plus randomized frames against a
// coordinate-division reference model; a sync ROM is modelled here.
module tb_sprite_scaler_blit;
  localparam int SPR_W = 84, SPR_H = 67, SCALE = 2, ADDR_W = 13, IDX_W = 4;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic reset_n, blank, enable, flip_x, pix_hit, blank_o;
  logic [9:0] DrawX, DrawY, spr_x, spr_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0] rom_q, pix_idx;
  logic [IDX_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

  sprite_scaler_blit #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(SCALE), .ADDR_W(ADDR_W),
                       .IDX_W(IDX_W), .TRANSP_IDX(0)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .enable(enable), .spr_x(spr_x), .spr_y(spr_y), .flip_x(flip_x), .rom_addr(rom_addr),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_hit(pix_hit), .blank_o(blank_o));

  always @(posedge vga_clk) rom_q <= rom_mem[rom_addr];

  typedef struct { bit hit; int idx; bit blk; } exp_t;
  typedef struct { int sx, sy, fl, chg_line, chg_x, px, py, chk_addr, exp_addr, exp_hit, exp_idx; } vec_t;

  int checks = 0, failures = 0;
  bit m_valid, m_lf, rand_blank, rand_en, churn_en;
  int m_lx, m_ly, m_last_addr;
  exp_t pipe [3];
  bit lines_sel [525];
  int probe_x, probe_y, probe_state, probe_wait, probe_ra, probe_idx, probe_hit;
  int chg_line, chg_x;
  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) begin
      pipe[i].hit = 1'b0; pipe[i].idx = 0; pipe[i].blk = 1'b0;
    end
  endtask

  // One pixel: model predicts from raster coordinates, then the DUT is sampled 1 ns after the edge.
  task automatic drive_pix(input int x, input int y);
    int col, row, addr, idx;
    bit inn, blk, en, hit;
    exp_t e;
    blk = (x < 640) && (y < 480);
    if (rand_blank && ($urandom_range(0, 15) == 0)) blk = !blk;
    en = rand_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    DrawX = 10'(x); DrawY = 10'(y); blank = blk; enable = en;
    if (x == 0 && y == 0) begin
      m_valid = 1'b1; m_lx = int'(spr_x); m_ly = int'(spr_y);
`ifdef SPR_MIRROR_EN
      m_lf = flip_x;
`else
      m_lf = 1'b0;
`endif
    end
    inn = m_valid && (x >= m_lx) && (x < m_lx + SPR_W * SCALE) && (y >= m_ly) && (y < m_ly + SPR_H * SCALE);
    hit = 1'b0; idx = 0;
    if (inn) begin
      col = (x - m_lx) / SCALE;
      row = (y - m_ly) / SCALE;
      addr = row * SPR_W + (m_lf ? (SPR_W - 1 - col) : col);
      m_last_addr = addr;
      idx = int'(rom_mem[addr]);
      hit = en && blk && (idx != 0);
    end
    e.hit = hit; e.idx = hit ? idx : 0; e.blk = blk;
    pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
    @(posedge vga_clk); #1;
    check("rom_addr", 32'(rom_addr), 32'(m_last_addr));
    check("pix_out", {pix_hit, 4'(pix_idx), blank_o}, {pipe[2].hit, 4'(pipe[2].idx), pipe[2].blk});
    if (probe_state == 1) begin
      probe_wait--;
      if (probe_wait == 0) begin
        probe_hit = int'(pix_hit); probe_idx = int'(pix_idx); probe_state = 2;
      end
    end
    if (x == probe_x && y == probe_y && probe_state == 0) begin
      probe_ra = int'(rom_addr); probe_state = 1; probe_wait = 2;
    end
  endtask

  task automatic reset_mid();
    reset_n = 1'b0;
    #1;
    check("rst_mid_out", {rom_addr, pix_hit, pix_idx, blank_o}, 32'd0);
    #1;
    reset_n = 1'b1;
    m_valid = 1'b0; m_last_addr = 0;
    clear_pipe();
  endtask

  // One frame: every line gets its line-start pixel; selected lines get a contiguous window.
  task automatic run_frame(input int sx, input int sy, input bit fl, input int rst_line);
    int xa, xb;
    spr_x = 10'(sx); spr_y = 10'(sy); flip_x = fl;
    xa = (sx >= 4) ? sx - 3 : 1;
    if (xa > 780) xa = 780;
    xb = xa + SPR_W * SCALE + 6;
    if (xb > 799) xb = 799;
    for (int y = 0; y < 525; y++) begin
      drive_pix(0, y);
      if (churn_en) begin
        spr_x = 10'($urandom_range(0, 1023)); spr_y = 10'($urandom_range(0, 1023));
        flip_x = 1'($urandom_range(0, 1));
      end
      if (y == chg_line) spr_x = 10'(chg_x);
      if (y == probe_y) begin
        for (int x = 1; x < 800; x++) drive_pix(x, y);
      end else if (lines_sel[y]) begin
        for (int x = xa; x <= xb; x++) drive_pix(x, y);
      end
      if (y == rst_line) reset_mid();
    end
  endtask

  task automatic clear_lines();
    for (int i = 0; i < 525; i++) lines_sel[i] = 1'b0;
  endtask

  task automatic mark_line(input int y);
    if (y >= 0 && y < 525) lines_sel[y] = 1'b1;
  endtask

  initial begin
    // sx, sy, fl, chg_line, chg_x, px, py, chk_addr, exp_addr, exp_hit, exp_idx
    tbl[0]  = '{0,   0,   0, -1, 0,   10,  0,   1, 5,    1, 5};
    tbl[1]  = '{100, 50,  0, -1, 0,   100, 50,  1, 0,    0, 0};
    tbl[2]  = '{100, 50,  0, -1, 0,   101, 50,  1, 0,    0, 0};
    tbl[3]  = '{100, 50,  0, -1, 0,   102, 50,  1, 1,    1, 1};
    tbl[4]  = '{100, 50,  0, -1, 0,   102, 52,  1, 85,   1, 5};
    tbl[5]  = '{100, 50,  0, -1, 0,   267, 183, 1, 5627, 1, 11};
    tbl[6]  = '{100, 50,  0, -1, 0,   268, 183, 1, 5627, 0, 0};
    tbl[7]  = '{100, 50,  0, -1, 0,   267, 184, 0, 0,    0, 0};
    tbl[8]  = '{99,  50,  0, -1, 0,   98,  50,  0, 0,    0, 0};
    tbl[9]  = '{600, 450, 0, -1, 0,   639, 450, 1, 19,   1, 3};
    tbl[10] = '{600, 450, 0, -1, 0,   640, 450, 1, 20,   0, 0};
    tbl[11] = '{600, 450, 0, -1, 0,   600, 479, 1, 1176, 1, 8};
    tbl[12] = '{600, 450, 0, -1, 0,   600, 480, 1, 1260, 0, 0};
    tbl[13] = '{600, 450, 0, -1, 0,   10,  451, 1, 83,   0, 0};
    tbl[14] = '{800, 0,   0, -1, 0,   799, 0,   0, 0,    0, 0};
    tbl[15] = '{0,   525, 0, -1, 0,   5,   0,   0, 0,    0, 0};
`ifdef SPR_MIRROR_EN
    tbl[16] = '{0,   0,   1, -1, 0,   0,   0,   1, 83,   1, 3};
`else
    tbl[16] = '{0,   0,   1, -1, 0,   0,   0,   1, 0,    0, 0};
`endif
    tbl[17] = '{100, 0,   0, 10, 200, 100, 20,  1, 840,  1, 8};
    tbl[18] = '{100, 0,   0, 10, 200, 280, 20,  1, 923,  0, 0};
    tbl[19] = '{0,   500, 0, -1, 0,   10,  510, 1, 425,  0, 0};
    tbl[20] = '{0,   2,   0, -1, 0,   10,  1,   0, 0,    0, 0};

    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'(i);
    reset_n = 1'b0; DrawX = 10'd5; DrawY = 10'd7; blank = 1'b0; enable = 1'b1;
    spr_x = 10'd0; spr_y = 10'd7; flip_x = 1'b0;
    rand_blank = 1'b0; rand_en = 1'b0; churn_en = 1'b0; chg_line = -1; chg_x = 0;
    probe_x = 9999; probe_y = 9999; probe_state = 0; probe_wait = 0;
    m_valid = 1'b0; m_lf = 1'b0; m_lx = 0; m_ly = 0; m_last_addr = 0;
    clear_pipe(); clear_lines();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_pix", {pix_hit, 4'(pix_idx), blank_o}, 6'd0);
    reset_n = 1'b1;

    // Before any frame start the sprite must stay dark even where it would overlap.
    for (int x = 0; x < 30; x++) drive_pix(x, 7);

    foreach (tbl[i]) begin
      clear_lines();
      mark_line(tbl[i].py - 1); mark_line(tbl[i].py + 1);
      probe_x = tbl[i].px; probe_y = tbl[i].py; probe_state = 0;
      chg_line = tbl[i].chg_line; chg_x = tbl[i].chg_x;
      run_frame(tbl[i].sx, tbl[i].sy, 1'(tbl[i].fl), -1);
      check($sformatf("vec%0d_seen", i), 32'(probe_state), 32'd2);
      if (tbl[i].chk_addr != 0) check($sformatf("vec%0d_addr", i), 32'(probe_ra), 32'(tbl[i].exp_addr));
      check($sformatf("vec%0d_hit", i), 32'(probe_hit), 32'(tbl[i].exp_hit));
      check($sformatf("vec%0d_idx", i), 32'(probe_idx), 32'(tbl[i].exp_idx));
    end

    probe_x = 9999; probe_y = 9999; chg_line = -1;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rand_blank = 1'b1; rand_en = 1'b1; churn_en = 1'b1;
    for (int f = 0; f < 10; f++) begin
      int sx, sy;
      sx = (f % 3 == 0) ? $urandom_range(560, 810) : $urandom_range(0, 620);
      sy = (f % 4 == 1) ? $urandom_range(420, 530) : $urandom_range(0, 400);
      clear_lines();
      for (int k = 0; k < 3; k++) mark_line(sy + k);
      for (int k = 128; k < 136; k++) mark_line(sy + k);
      for (int k = 478; k < 482; k++) mark_line(k);
      for (int k = 0; k < 6; k++) mark_line($urandom_range(0, 524));
      run_frame(sx, sy, 1'($urandom_range(0, 1)), (f == 5) ? sy + 3 : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
